// File: rtl/alu_exec_pkg.sv
// Shared constants for the execute-stage ALU block.
//   - alu_op class codes driven by the control unit
//   - alu_decode operation codes consumed by alu_core
package alu_exec_pkg;

    // alu_op classes
    localparam logic [3:0] OP_MEM = 4'b0000;  // load/store address: ADD
    localparam logic [3:0] OP_BR  = 4'b0001;  // conditional branch
    localparam logic [3:0] OP_R   = 4'b0010;  // register-register ALU
    localparam logic [3:0] OP_I   = 4'b0011;  // register-immediate ALU
    localparam logic [3:0] OP_LUI = 4'b0100;  // load upper immediate: PASSB

    // alu_decode operations
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;
    localparam logic [3:0] ALU_NOP   = 4'b1111;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 32-bit ALU.
// Ports:
//   alu_decode - operation code (ALU_* from alu_exec_pkg)
//   a, b       - operands
//   result     - operation result; unknown codes and NOP give zero
module alu_core
    import alu_exec_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [3:0]      alu_decode,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (alu_decode)
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_ADD:   result = a + b;
            ALU_XOR:   result = a ^ b;
            ALU_SLL:   result = a << shamt;
            ALU_SRL:   result = a >> shamt;
            ALU_SUB:   result = a - b;
            ALU_SRA:   result = $signed(a) >>> shamt;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, a < b};
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage of the single-cycle RV32I datapath: ALU-control decoder,
// operand-B mux, ALU and branch-condition logic, plus registered debug copies.
// Ports:
//   CLK, rst        - clock and synchronous active-high reset (registers only)
//   instr           - instruction; funct3 = [14:12], funct7 = [31:25]
//   alu_op          - class code from the control unit
//   rda, rdb        - register operands rs1 / rs2
//   imm_ex          - sign-extended immediate
//   alu_src         - selects imm_ex (1) or rdb (0) as operand B
//   rdx             - selected operand B
//   alu_decode      - decoded ALU operation
//   result, confirm - ALU result and branch-taken flag (combinational)
//   result_q, confirm_q - the same, registered on CLK
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] rda,
    input  logic [XLEN-1:0] rdb,
    input  logic [XLEN-1:0] imm_ex,
    input  logic            alu_src,
    output logic [XLEN-1:0] rdx,
    output logic [3:0]      alu_decode,
    output logic [XLEN-1:0] result,
    output logic            confirm,
    output logic [XLEN-1:0] result_q,
    output logic            confirm_q
);

    logic [2:0] funct3;
    logic       funct7_b5;
    logic       unused_instr;

    assign funct3       = instr[14:12];
    assign funct7_b5    = instr[30];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:0]};

    assign rdx = alu_src ? imm_ex : rdb;

    always_comb begin
        alu_decode = ALU_NOP;
        case (alu_op)
            OP_MEM: alu_decode = ALU_ADD;
            OP_BR: begin
                // Branches compare via SUB (equality) or set-less-than (ordering)
                case (funct3)
                    3'b000, 3'b001: alu_decode = ALU_SUB;
                    3'b100, 3'b101: alu_decode = ALU_SLT;
                    3'b110, 3'b111: alu_decode = ALU_SLTU;
                    default:        alu_decode = ALU_NOP;
                endcase
            end
            OP_R, OP_I: begin
                case (funct3)
                    // No SUBI: funct7[5] of an I-type is immediate bits there
                    3'b000:  alu_decode = (alu_op == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_decode = ALU_SLL;
                    3'b010:  alu_decode = ALU_SLT;
                    3'b011:  alu_decode = ALU_SLTU;
                    3'b100:  alu_decode = ALU_XOR;
                    3'b101:  alu_decode = funct7_b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_decode = ALU_OR;
                    default: alu_decode = ALU_AND;
                endcase
            end
            OP_LUI:  alu_decode = ALU_PASSB;
            default: alu_decode = ALU_NOP;
        endcase
    end

    alu_core #(
        .XLEN (XLEN)
    ) u_alu_core (
        .alu_decode (alu_decode),
        .a          (rda),
        .b          (rdx),
        .result     (result)
    );

    always_comb begin
        confirm = 1'b0;
        if (alu_op == OP_BR) begin
            case (funct3)
                3'b000:         confirm = (result == '0);
                3'b001:         confirm = (result != '0);
                3'b100, 3'b110: confirm = result[0];
                3'b101, 3'b111: confirm = ~result[0];
                default:        confirm = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            result_q  <= '0;
            confirm_q <= 1'b0;
        end else begin
            result_q  <= result;
            confirm_q <= confirm;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_alu_exec_unit;

    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = '0;
    logic [3:0]  alu_op = '0;
    logic [31:0] rda = '0;
    logic [31:0] rdb = '0;
    logic [31:0] imm_ex = '0;
    logic        alu_src = 1'b0;
    logic [31:0] rdx;
    logic [3:0]  alu_decode;
    logic [31:0] result;
    logic        confirm;
    logic [31:0] result_q;
    logic        confirm_q;

    typedef struct {
        logic [31:0] rdx;
        logic [3:0]  dec;
        logic [31:0] res;
        logic        conf;
    } comb_exp_t;

    typedef struct {
        logic [31:0] res;
        logic        conf;
    } reg_exp_t;

    comb_exp_t comb_q[$];
    reg_exp_t  reg_q[$];
    string     comb_name_q[$];
    string     reg_name_q[$];

    int checks = 0;
    int failures = 0;
    logic issued = 1'b0;

    alu_exec_unit #(
        .XLEN (32)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .instr      (instr),
        .alu_op     (alu_op),
        .rda        (rda),
        .rdb        (rdb),
        .imm_ex     (imm_ex),
        .alu_src    (alu_src),
        .rdx        (rdx),
        .alu_decode (alu_decode),
        .result     (result),
        .confirm    (confirm),
        .result_q   (result_q),
        .confirm_q  (confirm_q)
    );

    always #5 CLK = ~CLK;

    task automatic check32(input string nm, input string field, input logic [31:0] got,
                           input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s %s got=%h want=%h", nm, field, got, want);
        end
    endtask

    // Apply one vector just after a rising edge and record what it must produce.
    task automatic drive(input string nm, input logic r, input logic [31:0] i,
                         input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic src, input logic [31:0] e_rdx,
                         input logic [3:0] e_dec, input logic [31:0] e_res, input logic e_conf);
        comb_exp_t ce;
        reg_exp_t  re;
        @(posedge CLK);
        #1;
        rst = r; instr = i; alu_op = op; rda = a; rdb = b; imm_ex = im; alu_src = src;
        ce.rdx = e_rdx; ce.dec = e_dec; ce.res = e_res; ce.conf = e_conf;
        re.res  = r ? 32'h0 : e_res;
        re.conf = r ? 1'b0 : e_conf;
        comb_q.push_back(ce);
        comb_name_q.push_back(nm);
        reg_q.push_back(re);
        reg_name_q.push_back(nm);
        issued = 1'b1;
    endtask

    // Monitor: comb outputs checked in the issue cycle, registers one edge later.
    initial begin
        logic reg_armed;
        comb_exp_t ce;
        reg_exp_t  re;
        string     nm;
        reg_armed = 1'b0;
        forever begin
            @(negedge CLK);
            if (reg_armed) begin
                if (reg_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL reg_underflow queue empty got=0 want=1");
                end else begin
                    re = reg_q.pop_front();
                    nm = reg_name_q.pop_front();
                    check32(nm, "result_q", result_q, re.res);
                    check32(nm, "confirm_q", {31'b0, confirm_q}, {31'b0, re.conf});
                end
            end
            reg_armed = 1'b0;
            if (issued) begin
                if (comb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL comb_underflow queue empty got=0 want=1");
                end else begin
                    ce = comb_q.pop_front();
                    nm = comb_name_q.pop_front();
                    check32(nm, "rdx", rdx, ce.rdx);
                    check32(nm, "alu_decode", {28'b0, alu_decode}, {28'b0, ce.dec});
                    check32(nm, "result", result, ce.res);
                    check32(nm, "confirm", {31'b0, confirm}, {31'b0, ce.conf});
                    reg_armed = 1'b1;
                end
            end
        end
    end

    initial begin
        //     name         rst   instr          op     rda            rdb            imm            src   rdx            dec      result         conf
        drive("reset_init", 1'b1, 32'h00000000, 4'hF, 32'h00000011, 32'h00000055, 32'h00000000, 1'b0, 32'h00000055, 4'hF, 32'h00000000, 1'b0);
        drive("addi",       1'b0, 32'h00500093, 4'h3, 32'h00000000, 32'h00000000, 32'h00000005, 1'b1, 32'h00000005, 4'h2, 32'h00000005, 1'b0);
        drive("add",        1'b0, 32'h002081B3, 4'h2, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 32'h00000005, 4'h2, 32'h0000000A, 1'b0);
        drive("sub",        1'b0, 32'h402081B3, 4'h2, 32'h00000003, 32'h00000005, 32'h00000000, 1'b0, 32'h00000005, 4'h6, 32'hFFFFFFFE, 1'b0);
        drive("sw_addr",    1'b0, 32'hFE20F0A3, 4'h0, 32'h00000100, 32'h00000000, 32'h00000008, 1'b1, 32'h00000008, 4'h2, 32'h00000108, 1'b0);
        drive("addi_neg",   1'b0, 32'h40008093, 4'h3, 32'h00001000, 32'h00000000, 32'hFFFFFC00, 1'b1, 32'hFFFFFC00, 4'h2, 32'h00000C00, 1'b0);
        drive("xor",        1'b0, 32'h0020C1B3, 4'h2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000000, 1'b0, 32'h0FF00FF0, 4'h3, 32'hFF00FF00, 1'b0);
        drive("sll",        1'b0, 32'h002091B3, 4'h2, 32'h00000001, 32'h00000021, 32'h00000000, 1'b0, 32'h00000021, 4'h4, 32'h00000002, 1'b0);
        drive("beq",        1'b0, 32'h00208063, 4'h1, 32'h00000007, 32'h00000007, 32'h00000000, 1'b0, 32'h00000007, 4'h6, 32'h00000000, 1'b1);
        drive("bne",        1'b0, 32'h00209063, 4'h1, 32'h00000007, 32'h00000007, 32'h00000000, 1'b0, 32'h00000007, 4'h6, 32'h00000000, 1'b0);
        drive("blt",        1'b0, 32'h0020C063, 4'h1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 32'h00000001, 4'h8, 32'h00000001, 1'b1);
        drive("bltu",       1'b0, 32'h0020E063, 4'h1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 32'h00000001, 4'h9, 32'h00000000, 1'b0);
        drive("bge",        1'b0, 32'h0020D063, 4'h1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 32'h00000001, 4'h8, 32'h00000001, 1'b0);
        drive("bgeu",       1'b0, 32'h0020F063, 4'h1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 32'h00000001, 4'h9, 32'h00000000, 1'b1);
        drive("br_f3_010",  1'b0, 32'h0020A063, 4'h1, 32'h00000007, 32'h00000007, 32'h00000000, 1'b0, 32'h00000007, 4'hF, 32'h00000000, 1'b0);
        drive("srai",       1'b0, 32'h4040D093, 4'h3, 32'h80000000, 32'h00000000, 32'h00000404, 1'b1, 32'h00000404, 4'h7, 32'hF8000000, 1'b0);
        drive("srli",       1'b0, 32'h0040D093, 4'h3, 32'h80000000, 32'h00000000, 32'h00000404, 1'b1, 32'h00000404, 4'h5, 32'h08000000, 1'b0);
        drive("lui_in_rst", 1'b1, 32'h000010B7, 4'h4, 32'h00000000, 32'h00000000, 32'h00001234, 1'b1, 32'h00001234, 4'hA, 32'h00001234, 1'b0);
        drive("beq_resume", 1'b0, 32'h00208063, 4'h1, 32'h00000009, 32'h00000009, 32'h00000000, 1'b0, 32'h00000009, 4'h6, 32'h00000000, 1'b1);
        drive("lui",        1'b0, 32'h000010B7, 4'h4, 32'h00000000, 32'h00000000, 32'h00001234, 1'b1, 32'h00001234, 4'hA, 32'h00001234, 1'b0);
        drive("illegal_op", 1'b0, 32'h00208063, 4'hF, 32'h00000009, 32'h00000003, 32'h00000000, 1'b0, 32'h00000003, 4'hF, 32'h00000000, 1'b0);

        @(posedge CLK);
        #1;
        issued = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        check32("drain", "pending", comb_q.size() + reg_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage block for the single-cycle RV32I datapath. It merges the ALU-control decoder, the operand-B select mux and the 32-bit ALU into one block. It sits between the register file, immediate generator and control unit on the input side, and data memory, the write-data mux and the branch AND gate on the output side. Result and branch flag are combinational (zero latency); registered copies are provided for debug and trace.

Parameters:
XLEN, 32, datapath width (only 32 supported)

Ports:
CLK  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
instr  input  32  current instruction; uses funct3 = [14:12] and funct7 = [31:25]
alu_op  input  4  class code from control unit
rda  input  32  register operand A (rs1)
rdb  input  32  register operand B (rs2)
imm_ex  input  32  sign-extended immediate
alu_src  input  1  0: operand B = rdb; 1: operand B = imm_ex
rdx  output  32  selected operand B (combinational)
alu_decode  output  4  decoded ALU operation (combinational)
result  output  32  ALU result (combinational)
confirm  output  1  branch-taken flag (combinational)
result_q  output  32  result registered on CLK
confirm_q  output  1  confirm registered on CLK

Behaviour:
- Operand mux: rdx = alu_src ? imm_ex : rdb. Pure combinational.
- alu_op classes:
  - 0000: load/store, forces ADD.
  - 0001: branch, decoded from funct3.
  - 0010: R-type, decoded from funct3 and funct7[5].
  - 0011: I-type ALU, decoded from funct3; funct7[5] is used only when funct3 = 101.
  - 0100: LUI, forces PASSB.
  - Any other alu_op gives alu_decode = 1111.
- alu_decode codes:
  - AND = 0000, OR = 0001, ADD = 0010, XOR = 0011
  - SLL = 0100, SRL = 0101, SUB = 0110, SRA = 0111
  - SLT = 1000, SLTU = 1001, PASSB = 1010, NOP = 1111
- R-type funct3 mapping:
  - 000 → ADD, or SUB when funct7[5] = 1
  - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR
  - 101 → SRL, or SRA when funct7[5] = 1
  - 110 → OR; 111 → AND
- I-type uses the same mapping, except funct3 = 000 is always ADD (no SUBI).
- Branch funct3 mapping:
  - 000 / 001 → SUB
  - 100 / 101 → SLT
  - 110 / 111 → SLTU
  - 010 / 011 → NOP
- ALU, with A = rda and B = rdx:
  - ADD and SUB wrap modulo 2^32; no overflow output.
  - Shift amount is B[4:0].
  - SRA replicates A[31].
  - SLT is a signed compare, SLTU unsigned; each returns 32'd1 or 32'd0.
  - PASSB returns B.
  - NOP returns 0.
- confirm:
  - Equals 0 unless alu_op = 0001.
  - For branches, by funct3:
    - 000 (BEQ): result == 0
    - 001 (BNE): result != 0
    - 100 (BLT): result[0]
    - 101 (BGE): ~result[0]
    - 110 (BLTU): result[0]
    - 111 (BGEU): ~result[0]
    - 010 / 011: 0
- Registers: on every rising CLK, result_q <= result and confirm_q <= confirm. If rst = 1 at the edge, both clear to 0.
- Reset behaviour:
  - Reset has no effect on the combinational outputs.
  - Reset asserted mid-operation clears only the registered outputs; the next edge with rst = 0 resumes capture.
- No X propagation on valid inputs; all case statements carry defaults.

Decomposition:
- Package alu_exec_pkg holds the alu_op class constants (OP_MEM, OP_BR, OP_R, OP_I, OP_LUI) and the alu_decode constants (ALU_AND … ALU_NOP).
- One sub-module, alu_core: purely combinational ALU taking alu_decode, A and B and producing result.
- The decoder, operand mux, confirm logic and output registers stay in the top level.

Test Plan:
- addi x1,x0,5 (instr = 0x00500093, alu_op = 0011, alu_src = 1, imm_ex = 5, rda = 0) → rdx = 5, alu_decode = 0010, result = 5, confirm = 0; result_q = 5 after the next edge.
- add then sub:
  - instr = 0x002081B3, alu_op = 0010, alu_src = 0, rda = 5, rdb = 5 → result = 10.
  - instr = 0x402081B3, rda = 3, rdb = 5 → alu_decode = 0110, result = 0xFFFFFFFE.
- sw address (alu_op = 0000, alu_src = 1, rda = 0x100, imm_ex = 8) → result = 0x108 regardless of funct3/funct7.
- Branches (alu_op = 0001, alu_src = 0):
  - BEQ, rda = rdb = 7 → confirm = 1; BNE with the same operands → confirm = 0.
  - BLT, rda = 0xFFFFFFFF, rdb = 1 → confirm = 1; BLTU with the same operands → confirm = 0.
- Shifts:
  - srai (funct7 = 0x20, funct3 = 101, alu_op = 0011), rda = 0x80000000, imm_ex = 0x404 → result = 0xF8000000.
  - srli (funct7 = 0) with the same operands → 0x08000000.
- Reset and illegal class:
  - rst = 1 across an edge with result = 0x1234 → result_q = 0, confirm_q = 0.
  - alu_op = 1111 → alu_decode = 1111, result = 0, confirm = 0.
